ahb_console_master: RTL and testbench
=====================================

Name: ahb_console_master

Overview:
- AHB-Lite initiator that drains a character FIFO into the VGA console register with single-beat word writes.
- Address and data phases are pipelined, so transfers run back-to-back at one per cycle when the slave is ready.
- Honours slave wait states, including the console scroll stall (HREADY low), and handles ERROR responses.
- Sits between a UART or CPU-side character source and the AHB interconnect port of the VGA peripheral.

Parameters:
- FIFO_DEPTH, 16: character FIFO entries; power of two, minimum 2.
- CONSOLE_ADDR, 32'h5000_0000: target address driven on every transfer; bits [23:0] must be zero.
- MAX_RETRY, 3: ERROR responses tolerated per character before it is dropped.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  reset, synchronous, active-low.
- char_valid  in  1  source has a character.
- char_data  in  8  character code.
- char_ready  out  1  FIFO can accept; a push happens when valid&ready.
- HADDR  out  32  transfer address.
- HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- HWRITE  out  1  always 1 while NONSEQ, 0 while IDLE.
- HSIZE  out  3  3'b010, word.
- HBURST  out  3  3'b000, SINGLE.
- HPROT  out  4  4'b0011.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  {24'h0, char}, data-phase value.
- HREADY  in  1  transfer-complete signal from the interconnect.
- HRESP  in  1  1 = ERROR.
- busy  out  1  FIFO non-empty or data phase pending.
- err_count  out  8  saturating count of dropped characters.

Behaviour:
- Reset (sampled at HCLK rising edge with HRESETn=0):
  - FIFO empty, char_ready=0 during reset and 1 afterwards.
  - HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, busy=0, err_count=0, retry counters=0.
- Reset mid-transfer: abandon the outstanding phase immediately and drop FIFO contents. The slave side is reset by the same HRESETn.
- FIFO:
  - Push when char_valid&char_ready; char_ready = !full.
  - A push and a pop in the same cycle are both performed, and the occupancy is unchanged.
  - A push into a full FIFO cannot occur.
- Address phase (state ADDR):
  - Entered when the FIFO is non-empty and no error recovery is in progress.
  - Drive HTRANS=NONSEQ, HADDR=CONSOLE_ADDR, HWRITE=1.
  - These values are held stable until sampled with HREADY=1.
  - On HREADY=1 the head entry moves to the data-phase register (dp_valid=1, dp_data=head) and is popped from the FIFO.
- Data phase:
  - HWDATA = {24'h0, dp_data}, held while HREADY=0.
  - Completes on HREADY=1 with HRESP=0: dp_valid clears unless a new address phase was accepted in the same cycle.
- Pipelining:
  - The next address phase may be driven during the current data phase.
  - Throughput is 1 character per cycle with zero wait states.
  - Latency from push into an empty FIFO to the NONSEQ cycle is 1 cycle, because the FIFO output is registered.
- Wait states: while HREADY=0, all outputs are frozen. There is no timeout, so a scroll stall may last any number of cycles.
- ERROR response (two-cycle protocol):
  - Cycle 1 (HREADY=0, HRESP=1): if a NONSEQ is pending, HTRANS is changed to IDLE in the next cycle, which cancels it. The entry stays in the FIFO and is not popped.
  - Cycle 2 (HREADY=1, HRESP=1): the failed character is re-pushed logically by holding it in a retry slot that has priority over the FIFO head.
  - The retry counter increments. If the counter reaches MAX_RETRY, the character is dropped, err_count increments (saturating at 255), and the counter clears.
  - After an error, at least one IDLE cycle is driven before the next NONSEQ.
- States: IDLE, ADDR, ERR_CANCEL, ERR_IDLE.
  - IDLE -> ADDR when work is available (FIFO or retry slot).
  - ADDR -> ADDR while work remains after acceptance; ADDR -> IDLE when no work remains.
  - Any state -> ERR_CANCEL on error cycle 1.
  - ERR_CANCEL -> ERR_IDLE on error cycle 2.
  - ERR_IDLE -> IDLE.
- busy = FIFO non-empty | dp_valid | retry slot valid.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE.
  - The state enum typedef.
  - The CONSOLE_ADDR default.
- Sub-module sync_fifo (parameterised width/depth, registered output, full/empty flags), instantiated once for the characters.

Test Plan:
- Push 'A'(8'h41) with HREADY=1 constant -> NONSEQ at HADDR=CONSOLE_ADDR one cycle after the push; HWDATA=32'h41 in the next cycle; busy falls after the data phase.
- Push 4 chars back-to-back with zero wait -> 4 consecutive NONSEQ cycles, with HWDATA lagging HADDR by one cycle and in the same order.
- Hold HREADY=0 for 50 cycles during the data phase of 'B' (scroll stall) -> HADDR/HTRANS/HWDATA=32'h42 stable throughout; the next transfer proceeds after HREADY rises.
- Fill the FIFO with FIFO_DEPTH chars while HREADY=0 -> char_ready=0 at 16 entries; no data is lost after HREADY=1 and all 16 are written in order.
- HRESP ERROR on 'C' three times -> a NONSEQ is cancelled to IDLE in each error cycle 2; the character is dropped after the 3rd error; err_count=1; the following char 'D' is written normally.
- Assert HRESETn=0 during a wait-stated data phase with 5 chars queued -> the next cycle shows HTRANS=IDLE, HWDATA=0, busy=0, and the FIFO is empty.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, console master FSM states and the
// default console register address shared by the console master.
package ahb_pkg;

  localparam logic [1:0]  HTRANS_IDLE      = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ    = 2'b10;
  localparam logic [2:0]  HSIZE_WORD       = 3'b010;
  localparam logic [2:0]  HBURST_SINGLE    = 3'b000;
  localparam logic [3:0]  HPROT_DATA       = 4'b0011;
  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h5000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ERR_CANCEL,
    ST_ERR_IDLE
  } cm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, head read from the storage registers.
// Ports: clk/rst_n, i_push/i_data, i_pop, o_data head, o_full/o_empty/o_count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_cnt;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign w_cnt   = r_wptr - r_rptr;
  assign o_count = w_cnt;
  assign o_full  = (w_cnt == (AW+1)'(DEPTH));
  assign o_empty = (w_cnt == '0);
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ahb_console_master.sv
// ahb_console_master: drains queued characters into the VGA console
// register with pipelined single-beat AHB-Lite word writes.
// Ports: HCLK/HRESETn; char_valid/char_data/char_ready source side;
// AHB-Lite master HADDR..HWDATA with HREADY/HRESP; busy, err_count.
module ahb_console_master
  import ahb_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter int          MAX_RETRY    = 3
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cm_state_t     r_state;
  logic          r_run;
  logic          r_dp_valid;
  logic [7:0]    r_dp_data;
  logic          r_rty_valid;
  logic [7:0]    r_rty_data;
  logic [7:0]    r_rty_cnt;
  logic [7:0]    r_err_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_data;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic [7:0]    w_rty_next;
  logic          w_nonseq;
  logic          w_work;
  logic          w_more;
  logic          w_accept;
  logic          w_err1;
  logic          w_err2;
  logic          w_ok;
  logic          w_drop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .i_push  (w_push),
    .i_data  (char_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign char_ready = r_run & ~w_full;
  assign w_push     = char_valid & char_ready;

  // Retry slot outranks the FIFO head.
  assign w_head   = r_rty_valid ? r_rty_data : w_fifo_data;
  assign w_work   = r_rty_valid | ~w_empty;
  assign w_nonseq = (r_state == ST_ADDR);
  assign w_accept = w_nonseq & HREADY;
  assign w_pop    = w_accept & ~r_rty_valid;
  // Work left once the head being accepted is gone.
  assign w_more   = r_rty_valid ? ~w_empty : (w_count > CW'(1));

  assign w_err1     = r_dp_valid & ~HREADY & HRESP;
  assign w_err2     = r_dp_valid & HREADY & HRESP;
  assign w_ok       = r_dp_valid & HREADY & ~HRESP;
  assign w_rty_next = r_rty_cnt + 8'd1;
  assign w_drop     = (w_rty_next == 8'(MAX_RETRY));

  assign HTRANS    = w_nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = w_nonseq ? CONSOLE_ADDR : 32'h0;
  assign HWRITE    = w_nonseq;
  assign HSIZE     = HSIZE_WORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = r_dp_valid ? {24'h0, r_dp_data} : 32'h0;
  assign busy      = ~w_empty | r_dp_valid | r_rty_valid;
  assign err_count = r_err_cnt;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_run       <= 1'b0;
      r_dp_valid  <= 1'b0;
      r_dp_data   <= 8'h0;
      r_rty_valid <= 1'b0;
      r_rty_data  <= 8'h0;
      r_rty_cnt   <= 8'h0;
      r_err_cnt   <= 8'h0;
    end else begin
      r_run <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (w_err1)      r_state <= ST_ERR_CANCEL;
          else if (w_work) r_state <= ST_ADDR;
        end
        ST_ADDR: begin
          // Error cycle 1 withdraws the waiting NONSEQ.
          if (w_err1)                r_state <= ST_ERR_CANCEL;
          else if (HREADY && !w_more) r_state <= ST_IDLE;
        end
        ST_ERR_CANCEL: begin
          if (HREADY) r_state <= ST_ERR_IDLE;
        end
        ST_ERR_IDLE: r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_dp_valid <= 1'b1;
        r_dp_data  <= w_head;
      end else if (HREADY) begin
        r_dp_valid <= 1'b0;
      end

      if (w_accept && r_rty_valid) r_rty_valid <= 1'b0;

      if (w_err2) begin
        if (w_drop) begin
          r_rty_cnt <= 8'h0;
          if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
          r_rty_valid <= 1'b1;
          r_rty_data  <= r_dp_data;
          r_rty_cnt   <= w_rty_next;
        end
      end else if (w_ok) begin
        r_rty_cnt <= 8'h0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_console_master.sv
// tb_ahb_console_master: directed stimulus against a queue-based model
// of the console master, plus hand-computed literal expectations.
module tb_ahb_console_master;

  localparam int          DEPTH = 16;
  localparam int          MAXR  = 3;
  localparam logic [31:0] CADDR = 32'h5000_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h0;
  logic        char_ready;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic        busy;
  logic [7:0]  err_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 HCLK = ~HCLK;

  ahb_console_master #(
    .FIFO_DEPTH   (DEPTH),
    .CONSOLE_ADDR (CADDR),
    .MAX_RETRY    (MAXR)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HPROT      (HPROT),
    .HMASTLOCK  (HMASTLOCK),
    .HWDATA     (HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .busy       (busy),
    .err_count  (err_count)
  );

  // Model: queue of waiting chars, retry slot, whether a transfer is
  // being offered, the data phase, and forced-idle bookkeeping.
  byte unsigned m_q[$];
  bit           m_live = 1'b0;
  bit           m_run, m_offer, m_cancel, m_rv, m_dv;
  int           m_gap, m_rc, m_err;
  byte unsigned m_rd, m_dd;

  always @(posedge HCLK) begin : model
    bit           push, acc, e1, e2, ok;
    int           pending;
    byte unsigned old_dd, cur;
    cyc++;
    if (!HRESETn) begin
      m_q.delete();
      m_live = 1'b1;
      m_run = 0; m_offer = 0; m_cancel = 0; m_rv = 0; m_dv = 0;
      m_gap = 0; m_rc = 0; m_err = 0; m_rd = 0; m_dd = 0;
    end else begin
      push    = char_valid && m_run && (m_q.size() < DEPTH);
      acc     = m_offer && HREADY;
      e1      = m_dv && !HREADY && HRESP;
      e2      = m_dv && HREADY && HRESP;
      ok      = m_dv && HREADY && !HRESP;
      pending = m_q.size() + int'(m_rv);
      old_dd  = m_dd;
      if (e1 && !m_cancel) begin
        m_cancel = 1; m_offer = 0;
      end else if (m_cancel) begin
        if (HREADY) begin m_cancel = 0; m_gap = 1; end
      end else if (m_gap > 0) begin
        m_gap--; m_offer = 0;
      end else if (acc) begin
        m_offer = (pending - 1) > 0;
      end else if (!m_offer) begin
        m_offer = pending > 0;
      end
      if (acc) begin
        if (m_rv) begin cur = m_rd; m_rv = 0; end
        else cur = m_q.pop_front();
        m_dv = 1; m_dd = cur;
      end else if (m_dv && HREADY) begin
        m_dv = 0;
      end
      if (e2) begin
        if (m_rc + 1 >= MAXR) begin
          m_rc = 0;
          if (m_err < 255) m_err++;
        end else begin
          m_rv = 1; m_rd = old_dd; m_rc = m_rc + 1;
        end
      end else if (ok) begin
        m_rc = 0;
      end
      if (push) m_q.push_back(char_data);
      m_run = 1;
    end
  end

  always @(negedge HCLK) begin : cmp
    logic [87:0] act, exp;
    logic [31:0] e_wd;
    logic        e_busy, e_rdy;
    if (m_live) begin
      e_wd   = m_dv ? {24'h0, m_dd} : 32'h0;
      e_busy = (m_q.size() > 0) || m_dv || m_rv;
      e_rdy  = m_run && (m_q.size() < DEPTH);
      act = {HTRANS, HADDR, HWRITE, HWDATA, busy, err_count,
             char_ready, HSIZE, HBURST, HPROT, HMASTLOCK};
      exp = {(m_offer ? 2'b10 : 2'b00), (m_offer ? CADDR : 32'h0),
             m_offer, e_wd, e_busy, 8'(m_err), e_rdy,
             3'b010, 3'b000, 4'b0011, 1'b0};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_model cyc=%0d got=%h want=%h", cyc, act, exp);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push1(input logic [7:0] c);
    char_valid = 1'b1;
    char_data  = c;
    tick();
    char_valid = 1'b0;
  endtask

  logic [1:0]   tr [8];
  logic [31:0]  wd [8];
  byte unsigned t2c [4];
  byte unsigned got [$];
  int           unstable, ph, nerr, ncan, npend;
  bit           seen_d;

  initial begin
    t2c = '{8'h31, 8'h32, 8'h33, 8'h34};
    repeat (3) tick();
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_ready", 32'(char_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_errc", 32'(err_count), 32'h0);
    HRESETn = 1'b1;
    tick();
    chk("ready_after_rst", 32'(char_ready), 32'h1);

    // single 'A'
    push1(8'h41);
    chk("a_idle_at_push", 32'(HTRANS), 32'h0);
    tick();
    chk("a_nonseq", 32'(HTRANS), 32'h2);
    chk("a_haddr", HADDR, CADDR);
    chk("a_hwrite", 32'(HWRITE), 32'h1);
    tick();
    chk("a_hwdata", HWDATA, 32'h41);
    chk("a_busy_dp", 32'(busy), 32'h1);
    tick();
    chk("a_busy_end", 32'(busy), 32'h0);

    // four back-to-back
    for (int k = 0; k < 8; k++) begin
      char_valid = (k < 4);
      if (k < 4) char_data = t2c[k];
      tick();
      tr[k] = HTRANS;
      wd[k] = HWDATA;
    end
    char_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b2b_htrans%0d", k), 32'(tr[k]),
          (k >= 1 && k <= 4) ? 32'h2 : 32'h0);
      if (k >= 2 && k <= 5) chk($sformatf("b2b_hwdata%0d", k), wd[k],
                                {24'h0, t2c[k-2]});
    end

    // scroll stall during 'B' data phase
    char_valid = 1'b1; char_data = 8'h42; tick();
    char_data = 8'h45; tick();
    char_valid = 1'b0; tick();
    chk("stall_start_wd", HWDATA, 32'h42);
    chk("stall_start_tr", 32'(HTRANS), 32'h2);
    HREADY = 1'b0;
    unstable = 0;
    repeat (50) begin
      tick();
      if (HTRANS !== 2'b10 || HADDR !== CADDR || HWDATA !== 32'h42)
        unstable++;
    end
    chk("stall_stable", 32'(unstable), 32'h0);
    HREADY = 1'b1;
    tick();
    chk("stall_next_wd", HWDATA, 32'h45);
    tick();
    chk("stall_done_busy", 32'(busy), 32'h0);

    // fill while stalled
    HREADY = 1'b0;
    char_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      char_data = 8'(8'h60 + i);
      tick();
    end
    chk("full_ready", 32'(char_ready), 32'h0);
    char_data = 8'h7F;
    tick();
    char_valid = 1'b0;
    chk("full_ready_hold", 32'(char_ready), 32'h0);
    HREADY = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (HWDATA != 32'h0) got.push_back(HWDATA[7:0]);
    end
    chk("full_count", 32'(got.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      chk($sformatf("full_order%0d", i), 32'(got[i]), 32'(8'h60 + i));

    // ERROR on 'C' three times, then 'D'
    char_valid = 1'b1; char_data = 8'h43; tick();
    char_data = 8'h44; tick();
    char_valid = 1'b0;
    ph = 0; nerr = 0; ncan = 0; npend = 0; seen_d = 0;
    for (int c = 0; c < 80 && !seen_d; c++) begin
      if (ph == 1) begin
        if (HTRANS == 2'b00) ncan++;
        HREADY = 1'b1; HRESP = 1'b1; ph = 2; nerr++;
      end else if (ph == 2) begin
        HREADY = 1'b1; HRESP = 1'b0; ph = 0;
      end else if (HWDATA == 32'h43) begin
        if (HTRANS == 2'b10) npend++;
        HREADY = 1'b0; HRESP = 1'b1; ph = 1;
      end else begin
        HREADY = 1'b1; HRESP = 1'b0;
      end
      if (HWDATA == 32'h44) seen_d = 1;
      tick();
    end
    HREADY = 1'b1; HRESP = 1'b0;
    chk("err_d_written", 32'(seen_d), 32'h1);
    chk("err_attempts", 32'(nerr), 32'h3);
    chk("err_pending", 32'(npend), 32'h3);
    chk("err_cancels", 32'(ncan), 32'h3);
    chk("err_count", 32'(err_count), 32'h1);
    tick();

    // reset mid data phase with 5 queued
    HREADY = 1'b0;
    char_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      char_data = 8'(8'h70 + i);
      tick();
    end
    char_valid = 1'b0;
    HREADY = 1'b1; tick();
    HREADY = 1'b0; tick(); tick();
    chk("rst2_pre_wd", HWDATA, 32'h70);
    HRESETn = 1'b0;
    tick();
    chk("rst2_htrans", 32'(HTRANS), 32'h0);
    chk("rst2_hwdata", HWDATA, 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_ready", 32'(char_ready), 32'h0);
    chk("rst2_errc", 32'(err_count), 32'h0);
    HRESETn = 1'b1; HREADY = 1'b1;
    tick();
    chk("rst2_ready_up", 32'(char_ready), 32'h1);
    repeat (3) tick();
    chk("rst2_quiet_tr", 32'(HTRANS), 32'h0);
    chk("rst2_quiet_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
